// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-bounded arbiter sharing one FIFO write port among NUM_REQ
// valid/ready producers. All state lives in the write clock domain.

module fifo_wr_arb_lane #(
    parameter int DW = 8
) (
    input  logic          gnt_i,
    input  logic          valid_i,
    input  logic [DW-1:0] data_i,
    input  logic          fifo_full_i,
    output logic          ready_o,
    output logic          wr_o,
    output logic [DW-1:0] data_o
);
    assign ready_o = gnt_i & ~fifo_full_i;
    assign wr_o    = ready_o & valid_i;
    // Zero when not granted so the top can OR the lanes together as a mux.
    assign data_o  = gnt_i ? data_i : '0;
endmodule

module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                          wrclk,
    input  logic                          wrst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic                          wr_en,
    output logic [DATA_WIDTH-1:0]         data_in,
    output logic [NUM_REQ-1:0]            gnt_onehot,
    output logic                          busy,
    output logic [15:0]                   stall_cnt
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int BW    = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0]    LAST_BEAT = BW'(MAX_BURST - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t               state_q;
    logic [IDX_W-1:0]     gnt_idx_q;
    logic [IDX_W-1:0]     last_gnt_q;
    logic [NUM_REQ-1:0]   gnt_onehot_q;
    logic                 busy_q;
    logic [BW-1:0]        beat_cnt_q;
    logic [15:0]          stall_cnt_q;

    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_data_a;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] lane_data;
    logic [NUM_REQ-1:0]                 lane_wr;
    logic [DATA_WIDTH-1:0]              data_mux;
    logic                               gnt_valid;
    logic                               rr_hit;
    logic [IDX_W-1:0]                   rr_sel;

    assign req_data_a = req_data;

    genvar g;
    generate
        for (g = 0; g < NUM_REQ; g++) begin : g_lane
            fifo_wr_arb_lane #(.DW(DATA_WIDTH)) u_lane (
                .gnt_i       (gnt_onehot_q[g]),
                .valid_i     (req_valid[g]),
                .data_i      (req_data_a[g]),
                .fifo_full_i (fifo_full),
                .ready_o     (req_ready[g]),
                .wr_o        (lane_wr[g]),
                .data_o      (lane_data[g])
            );
        end
    endgenerate

    always_comb begin
        data_mux = '0;
        for (int i = 0; i < NUM_REQ; i++) data_mux |= lane_data[i];
    end

    assign wr_en      = |lane_wr;
    assign data_in    = data_mux;
    assign gnt_valid  = |(gnt_onehot_q & req_valid);
    assign gnt_onehot = gnt_onehot_q;
    assign busy       = busy_q;
    assign stall_cnt  = stall_cnt_q;

    // Search starts just past the last owner so every requester gets a turn.
    always_comb begin
        logic [IDX_W-1:0] cand;
        rr_hit = 1'b0;
        rr_sel = '0;
        cand   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((int'(last_gnt_q) + k) % NUM_REQ);
            if (!rr_hit && req_valid[cand]) begin
                rr_hit = 1'b1;
                rr_sel = cand;
            end
        end
    end

    always_ff @(posedge wrclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state_q      <= IDLE;
            gnt_idx_q    <= '0;
            last_gnt_q   <= LAST_IDX;
            gnt_onehot_q <= '0;
            busy_q       <= 1'b0;
            beat_cnt_q   <= '0;
            stall_cnt_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rr_hit) begin
                        state_q      <= BURST;
                        gnt_idx_q    <= rr_sel;
                        gnt_onehot_q <= NUM_REQ'(1) << rr_sel;
                        busy_q       <= 1'b1;
                        beat_cnt_q   <= '0;
                    end
                end
                BURST: begin
                    if (!gnt_valid || (wr_en && beat_cnt_q == LAST_BEAT)) begin
                        state_q      <= IDLE;
                        last_gnt_q   <= gnt_idx_q;
                        gnt_onehot_q <= '0;
                        busy_q       <= 1'b0;
                        beat_cnt_q   <= '0;
                    end else if (wr_en) begin
                        beat_cnt_q <= beat_cnt_q + 1'b1;
                    end else if (stall_cnt_q != 16'hFFFF) begin
                        // Granted beat is valid but the FIFO is full.
                        stall_cnt_q <= stall_cnt_q + 16'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    a_no_overflow: assert property (@(posedge wrclk) disable iff (!wrst_n) !(wr_en && fifo_full));
    a_onehot:      assert property (@(posedge wrclk) disable iff (!wrst_n) $onehot0(gnt_onehot_q));
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: a queue-based requester/arbiter model is
// compared every cycle, plus literal expectations on logged writes and grants.

module tb_fifo_wr_arbiter;
    localparam int N  = 4;
    localparam int DW = 8;
    localparam int MB = 4;

    logic              wrclk = 1'b0;
    logic              wrst_n = 1'b0;
    logic [N-1:0]      req_valid;
    logic [N*DW-1:0]   req_data;
    logic [N-1:0]      req_ready;
    logic              fifo_full;
    logic              wr_en;
    logic [DW-1:0]     data_in;
    logic [N-1:0]      gnt_onehot;
    logic              busy;
    logic [15:0]       stall_cnt;

    always #5 wrclk = ~wrclk;

    fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .wrclk      (wrclk),
        .wrst_n     (wrst_n),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .fifo_full  (fifo_full),
        .wr_en      (wr_en),
        .data_in    (data_in),
        .gnt_onehot (gnt_onehot),
        .busy       (busy),
        .stall_cnt  (stall_cnt)
    );

    int n_pass = 0;
    int n_total = 0;

    logic [7:0] q [N][$];
    bit         en [N];
    bit         rnd;
    logic       full_v;
    logic [N-1:0] acc;

    int m_own, m_beats, m_last, m_stall;

    logic [7:0] wlog [$];
    int         wcyc [$];
    int         glog [$];
    int         cyc_n;
    logic [N-1:0] prev_gnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic apply();
        if (rnd) begin
            req_valid = N'($urandom);
            req_data  = $urandom;
            fifo_full = 1'($urandom);
        end else begin
            for (int i = 0; i < N; i++) begin
                req_valid[i] = en[i] && (q[i].size() > 0);
                req_data[i*DW +: DW] = (q[i].size() > 0) ? q[i][0] : 8'h00;
            end
            fifo_full = full_v;
        end
    endtask

    task automatic check_cycle();
        logic [N-1:0] e_gnt, e_rdy;
        logic         e_wr;
        logic [7:0]   e_data;
        bit           e_busy;
        acc = '0;
        if (!wrst_n) begin
            chk("rst_wr_en", 32'(wr_en), 32'd0);
            chk("rst_req_ready", 32'(req_ready), 32'd0);
            chk("rst_gnt", 32'(gnt_onehot), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_stall", 32'(stall_cnt), 32'd0);
            chk("rst_data_in", 32'(data_in), 32'd0);
            m_own = -1; m_beats = 0; m_last = N - 1; m_stall = 0;
        end else begin
            e_busy = (m_own >= 0);
            e_gnt  = e_busy ? (N'(1) << m_own) : '0;
            e_rdy  = (e_busy && !fifo_full) ? e_gnt : '0;
            e_wr   = ((req_valid & e_gnt) != 0) && !fifo_full;
            e_data = 8'h00;
            if (e_busy) e_data = req_data[m_own*DW +: DW];
            chk("gnt_onehot", 32'(gnt_onehot), 32'(e_gnt));
            chk("busy", 32'(busy), 32'(e_busy));
            chk("req_ready", 32'(req_ready), 32'(e_rdy));
            chk("wr_en", 32'(wr_en), 32'(e_wr));
            chk("data_in", 32'(data_in), 32'(e_data));
            chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
            acc = e_rdy & req_valid;
            if (!e_busy) begin
                for (int k = 1; k <= N; k++) begin
                    int c;
                    c = (m_last + k) % N;
                    if (m_own < 0 && req_valid[c]) begin
                        m_own = c;
                        m_beats = 0;
                    end
                end
            end else if (!req_valid[m_own]) begin
                m_last = m_own;
                m_own = -1;
            end else if (fifo_full) begin
                if (m_stall < 65535) m_stall++;
            end else begin
                m_beats++;
                if (m_beats == MB) begin
                    m_last = m_own;
                    m_own = -1;
                end
            end
        end
        if (wr_en) begin
            wlog.push_back(data_in);
            wcyc.push_back(cyc_n);
        end
        if (prev_gnt == 0 && gnt_onehot != 0)
            for (int i = 0; i < N; i++) if (gnt_onehot[i]) glog.push_back(i);
        prev_gnt = gnt_onehot;
        cyc_n++;
    endtask

    task automatic cyc();
        apply();
        @(negedge wrclk);
        check_cycle();
        @(posedge wrclk);
        #1;
        for (int i = 0; i < N; i++) if (acc[i]) void'(q[i].pop_front());
    endtask

    task automatic clear_logs();
        wlog.delete(); wcyc.delete(); glog.delete();
        cyc_n = 0;
        prev_gnt = '0;
    endtask

    task automatic do_reset();
        rnd = 1'b1;
        wrst_n = 1'b0;
        repeat (3) cyc();
        rnd = 1'b0;
        for (int i = 0; i < N; i++) begin
            q[i].delete();
            en[i] = 1'b0;
        end
        full_v = 1'b0;
        wrst_n = 1'b1;
        clear_logs();
    endtask

    function automatic logic [31:0] wl(input int j);
        return (j < wlog.size()) ? 32'(wlog[j]) : 32'hDEAD;
    endfunction
    function automatic logic [31:0] wc(input int j);
        return (j < wcyc.size()) ? 32'(wcyc[j]) : 32'hDEAD;
    endfunction
    function automatic logic [31:0] gl(input int j);
        return (j < glog.size()) ? 32'(glog[j]) : 32'hDEAD;
    endfunction

    initial begin
        int exp_c2 [6];
        int exp_g3 [5];
        int exp_c4 [4];
        int exp_g5 [3];
        logic [7:0] exp_w5 [6];
        exp_c2 = '{1, 2, 3, 4, 6, 7};
        exp_g3 = '{0, 1, 2, 3, 0};
        exp_c4 = '{1, 2, 6, 7};
        exp_g5 = '{2, 3, 0};
        exp_w5 = '{8'h20, 8'h21, 8'h30, 8'h31, 8'h00, 8'h01};
        rnd = 1'b0;
        full_v = 1'b0;
        req_valid = '0;
        req_data = '0;
        fifo_full = 1'b0;
        clear_logs();

        // Reset held with random inputs, then a lone requester with 6 beats.
        do_reset();
        for (int j = 0; j < 6; j++) q[1].push_back(8'(8'h10 + j));
        en[1] = 1'b1;
        repeat (12) cyc();
        chk("t2_nwrites", 32'(wlog.size()), 32'd6);
        for (int j = 0; j < 6; j++) begin
            chk("t2_wdata", wl(j), 32'(8'h10 + j));
            chk("t2_wcycle", wc(j), 32'(exp_c2[j]));
        end
        chk("t2_grants", 32'(glog.size()), 32'd2);
        chk("t2_gnt0", gl(0), 32'd1);

        // All four requesters saturated.
        do_reset();
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < 12; j++) q[i].push_back(8'(i*16 + j));
            en[i] = 1'b1;
        end
        repeat (25) cyc();
        chk("t3_nwrites", 32'(wlog.size()), 32'd20);
        for (int j = 0; j < 5; j++) chk("t3_gnt_order", gl(j), 32'(exp_g3[j]));
        chk("t3_w4", wl(4), 32'h10);
        chk("t3_w16", wl(16), 32'h04);
        chk("t3_c4", wc(4), 32'd6);

        // FIFO full for 3 cycles after the 2nd beat.
        do_reset();
        for (int j = 0; j < 4; j++) q[0].push_back(8'(8'hA0 + j));
        en[0] = 1'b1;
        repeat (3) cyc();
        full_v = 1'b1;
        repeat (3) cyc();
        full_v = 1'b0;
        repeat (4) cyc();
        chk("t4_stall_cnt", 32'(stall_cnt), 32'd3);
        chk("t4_nwrites", 32'(wlog.size()), 32'd4);
        for (int j = 0; j < 4; j++) begin
            chk("t4_wdata", wl(j), 32'(8'hA0 + j));
            chk("t4_wcycle", wc(j), 32'(exp_c4[j]));
        end

        // Requester 2 runs dry after 2 beats; 3 then 0 follow.
        do_reset();
        q[2].push_back(8'h20); q[2].push_back(8'h21);
        en[2] = 1'b1;
        cyc();
        q[3].push_back(8'h30); q[3].push_back(8'h31);
        q[0].push_back(8'h00); q[0].push_back(8'h01);
        en[3] = 1'b1; en[0] = 1'b1;
        repeat (12) cyc();
        for (int j = 0; j < 3; j++) chk("t5_gnt_order", gl(j), 32'(exp_g5[j]));
        for (int j = 0; j < 6; j++) chk("t5_wdata", wl(j), 32'(exp_w5[j]));

        // Reset during the 3rd beat of requester 2.
        do_reset();
        for (int j = 0; j < 4; j++) q[2].push_back(8'(8'h20 + j));
        en[2] = 1'b1;
        repeat (3) cyc();
        q[0].push_back(8'h05); q[0].push_back(8'h06);
        en[0] = 1'b1;
        apply();
        #2;
        chk("t6_pre_wr_en", 32'(wr_en), 32'd1);
        chk("t6_pre_data", 32'(data_in), 32'h22);
        wrst_n = 1'b0;
        #1;
        chk("t6_async_wr_en", 32'(wr_en), 32'd0);
        chk("t6_async_ready", 32'(req_ready), 32'd0);
        chk("t6_async_gnt", 32'(gnt_onehot), 32'd0);
        chk("t6_async_busy", 32'(busy), 32'd0);
        chk("t6_async_data", 32'(data_in), 32'd0);
        cyc();
        wrst_n = 1'b1;
        clear_logs();
        repeat (8) cyc();
        chk("t6_gnt0", gl(0), 32'd0);
        chk("t6_gnt1", gl(1), 32'd2);
        chk("t6_w0", wl(0), 32'h05);
        chk("t6_w2", wl(2), 32'h22);
        chk("t6_w3", wl(3), 32'h23);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
